// File: rtl/adder32_pkg.sv
// Shared definitions for the integer datapath.
package adder32_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead slice. Sum bits use internal lookahead carries.
// Group P/G feed the second-level lookahead in the parent.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       P,
  output logic       G
);
  logic [3:0] p, g;
  logic [3:0] c;

  // Bit propagate/generate, flattened carries, and group terms.
  // The group terms do not depend on cin.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
    P    = &p;
    G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

// File: rtl/adder32.sv
// 32-bit adder/subtractor with combinational result and flags, plus a
// registered copy. The carry tree uses eight cla4 slices and a
// second-level lookahead. The slice carries are flattened sums of
// products, so no carry ripples from one slice to the next.
module adder32
  import adder32_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Sub,
  input  logic            Cin,
  output logic [XLEN-1:0] OUT,
  output logic            Cout,
  output logic            Overflow,
  output logic            Zero,
  output logic [XLEN-1:0] OUT_Q,
  output logic            Cout_Q,
  output logic            Overflow_Q,
  output logic            Zero_Q
);
  localparam int NSLICE = XLEN / 4;

  logic [XLEN-1:0]   bx;
  logic              c0;
  logic [NSLICE-1:0] gp, gg;
  logic [NSLICE:0]   cg;
  logic [XLEN-1:0]   sum;

  // Effective operand and carry-in. Subtraction is A + ~B + 1.
  always_comb begin
    bx = Sub ? ~B : B;
    c0 = Sub ? 1'b1 : Cin;
  end

  genvar i;
  generate
    for (i = 0; i < NSLICE; i++) begin : g_slice
      cla4 u_cla4 (
        .a   (A[4*i +: 4]),
        .b   (bx[4*i +: 4]),
        .cin (cg[i]),
        .s   (sum[4*i +: 4]),
        .P   (gp[i]),
        .G   (gg[i])
      );
    end
  endgenerate

  // Second-level lookahead. Each slice carry is built as
  //   c[k] = OR_j ( G[j] & P[k-1..j+1] )  |  ( P[k-1..0] & c0 ).
  // Every term uses only group P/G and c0, so the logic is two levels
  // deep per slice carry.
  always_comb begin
    logic prod;
    prod  = 1'b0;
    cg    = '0;
    cg[0] = c0;
    for (int k = 1; k <= NSLICE; k++) begin
      prod = c0;
      for (int m = 0; m < k; m++) prod = prod & gp[m];
      cg[k] = prod;
      for (int j = 0; j < k; j++) begin
        prod = gg[j];
        for (int m = j + 1; m < k; m++) prod = prod & gp[m];
        cg[k] = cg[k] | prod;
      end
    end
  end

  // Combinational result and flags. Overflow uses the sign rule,
  // which is equivalent to c31 ^ c32.
  always_comb begin
    OUT      = sum;
    Cout     = cg[NSLICE];
    Overflow = (A[XLEN-1] == bx[XLEN-1]) && (sum[XLEN-1] != A[XLEN-1]);
    Zero     = ~|sum;
  end

  // Registered copy. Reset to all zeros, including Zero_Q, which
  // marks the copy as "no valid result yet".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_Q      <= '0;
      Cout_Q     <= 1'b0;
      Overflow_Q <= 1'b0;
      Zero_Q     <= 1'b0;
    end else begin
      OUT_Q      <= OUT;
      Cout_Q     <= Cout;
      Overflow_Q <= Overflow;
      Zero_Q     <= Zero;
    end
  end
endmodule

// File: tb/tb_adder32.sv
// Bench for adder32. A reference model computes results with wide
// integer arithmetic. Directed vectors check against hand-computed
// literals, and a negedge compare process checks every cycle.
module tb_adder32;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        Sub = 1'b0, Cin = 1'b0;
  logic [31:0] OUT, OUT_Q;
  logic        Cout, Overflow, Zero, Cout_Q, Overflow_Q, Zero_Q;

  int n_chk  = 0;
  int n_fail = 0;
  bit running = 1'b0;

  adder32 dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .Sub(Sub), .Cin(Cin),
    .OUT(OUT), .Cout(Cout), .Overflow(Overflow), .Zero(Zero),
    .OUT_Q(OUT_Q), .Cout_Q(Cout_Q), .Overflow_Q(Overflow_Q), .Zero_Q(Zero_Q)
  );

  always #5 CLK = ~CLK;

  // Reference result packed as {zero, ovf, cout, out}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    longint sa, sb, r;
    logic [32:0] u;
    logic [31:0] o;
    logic co, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      o  = a - b;
      co = (a >= b);
      r  = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      o  = u[31:0];
      co = u[32];
      r  = sa + sb + longint'(cin);
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {(o == 32'd0), ov, co, o};
  endfunction

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected registered copy: captures the model on each edge and
  // clears immediately on reset.
  logic [34:0] q_exp;
  always @(posedge CLK or posedge RST) begin
    if (RST) q_exp <= '0;
    else     q_exp <= model(A, B, Sub, Cin);
  end

  // Per-cycle compare of both the combinational and registered outputs.
  always @(negedge CLK) begin
    if (running) begin
      chk("comb", {Zero, Overflow, Cout, OUT}, model(A, B, Sub, Cin));
      chk("regq", {Zero_Q, Overflow_Q, Cout_Q, OUT_Q}, q_exp);
    end
  end

  // Apply one vector after the edge and compare it against literals.
  // The same literals also check the model itself.
  task automatic vec(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic cin, input logic [31:0] eo,
                     input logic ec, input logic ev, input logic ez);
    @(posedge CLK); #2;
    A = a; B = b; Sub = sub; Cin = cin;
    #1;
    chk(name, {Zero, Overflow, Cout, OUT}, {ez, ev, ec, eo});
    chk({name, "_model"}, model(a, b, sub, cin), {ez, ev, ec, eo});
  endtask

  logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    #2;
    chk("reset_q", {Zero_Q, Overflow_Q, Cout_Q, OUT_Q}, 35'd0);
    @(posedge CLK); #2;
    chk("reset_q_hold", {Zero_Q, Overflow_Q, Cout_Q, OUT_Q}, 35'd0);
    RST = 1'b0;
    running = 1'b1;

    vec("inc0",     32'h0,         32'd4, 1'b0, 1'b0, 32'h4,         1'b0, 1'b0, 1'b0);
    vec("inc4",     32'h4,         32'd4, 1'b0, 1'b0, 32'h8,         1'b0, 1'b0, 1'b0);
    vec("inc3fc",   32'h3FC,       32'd4, 1'b0, 1'b0, 32'h400,       1'b0, 1'b0, 1'b0);
    vec("wrap",     32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
    vec("ovf_add",  32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    vec("sub_5_7",  32'd5,         32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    vec("sub_7_5",  32'd7,         32'd5, 1'b1, 1'b0, 32'h2,         1'b1, 1'b0, 1'b0);
    vec("ovf_sub",  32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    vec("sub_eq",   32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    vec("cin_add",  32'hF,         32'd0, 1'b0, 1'b1, 32'h10,        1'b0, 1'b0, 1'b0);
    vec("cin_sub",  32'hF,         32'd0, 1'b1, 1'b1, 32'hF,         1'b1, 1'b0, 1'b0);

    // Registered path and asynchronous reset between edges.
    vec("add_3_4",  32'd3,         32'd4, 1'b0, 1'b0, 32'h7,         1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    chk("q_3_4", {Zero_Q, Overflow_Q, Cout_Q, OUT_Q}, {1'b0, 1'b0, 1'b0, 32'h7});
    #1 RST = 1'b1;
    #1;
    chk("q_async_rst", {Zero_Q, Overflow_Q, Cout_Q, OUT_Q}, 35'd0);
    chk("comb_in_rst", {Zero, Overflow, Cout, OUT}, {1'b0, 1'b0, 1'b0, 32'h7});
    @(posedge CLK); #1;
    chk("q_rst_hold", {Zero_Q, Overflow_Q, Cout_Q, OUT_Q}, 35'd0);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    chk("q_after_rst", {Zero_Q, Overflow_Q, Cout_Q, OUT_Q}, {1'b0, 1'b0, 1'b0, 32'h7});

    // Random operands with corner values mixed in. The negedge
    // process does the checking.
    for (int n = 0; n < 10000; n++) begin
      @(posedge CLK); #2;
      A   = pick();
      B   = pick();
      Sub = 1'($urandom_range(1));
      Cin = 1'($urandom_range(1));
    end
    @(posedge CLK); #2;
    running = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adder32.md
# adder32

32-bit two's-complement adder/subtractor used on the fetch-stage PC-increment path (PC_F + 4 → PC_Plus_4_F) and available to other stages. It produces a zero-latency combinational sum with carry, overflow and zero flags. It also holds a one-cycle registered copy of the result and flags for timing-relaxed consumers. The carry chain is a hierarchical carry-lookahead built from 4-bit CLA slices.

## Interface
- Parameters: none; width fixed at 32.
- CLK  input  1  rising-edge clock for the registered copy
- RST  input  1  reset, asynchronous, active-high; clears registered outputs only
- A  input  32  operand A
- B  input  32  operand B
- Sub  input  1  0 = A+B, 1 = A−B; tie 0 when unused
- Cin  input  1  carry-in for add; ignored when Sub=1; tie 0 when unused
- OUT  output  32  combinational result, modulo 2^32
- Cout  output  1  combinational carry out of bit 31
- Overflow  output  1  combinational signed overflow
- Zero  output  1  combinational, 1 when OUT == 0
- OUT_Q  output  32  registered OUT
- Cout_Q, Overflow_Q, Zero_Q  output  1 each  registered flags

## Operation
- Effective operand Bx = Sub ? ~B : B; effective carry-in c0 = Sub ? 1 : Cin.
- OUT = (A + Bx + c0) mod 2^32; Cout = bit 32 of the 33-bit sum.
- For subtract, Cout = 1 means no borrow (A ≥ B unsigned).
- Overflow = (A[31] == Bx[31]) && (OUT[31] != A[31]).
- Zero = ~|OUT.
- Carry tree: eight 4-bit CLA slices, each producing group propagate P and generate G. A second-level lookahead unit forms the slice carries c4…c28 and c32 from slice P/G and c0. No ripple between slices.
- Overflow may alternatively be computed as c31 XOR c32; both forms must agree.
- Wrap-around: 0xFFFFFFFF + 1 → OUT=0, Cout=1, Zero=1, Overflow=0.
- Inputs X or Z propagate X; no internal state affects the combinational outputs.

## Timing
- OUT, Cout, Overflow, Zero: purely combinational, zero latency. This is required because the PC register loads PC_Plus_4_F in the same cycle.
- Registered outputs capture their combinational counterparts on every rising CLK edge. Latency is 1 cycle and there is no enable.
- RST asserted, including mid-operation: OUT_Q, Cout_Q, Overflow_Q and Zero_Q go to 0 immediately, without waiting for a clock edge, and hold 0 while RST is high.
- Zero_Q resets to 0 even though OUT_Q=0; this is intentional, because the reset value means "no valid result."
- RST has no effect on the combinational outputs.
- First capture occurs on the first rising edge after RST deasserts.
- No handshake; the registered copy is valid every cycle after the first post-reset edge.

## Structure
- Sub-module cla4: inputs a[3:0], b[3:0], cin; outputs s[3:0], P, G.
  - Instantiated 8× via generate.
- The second-level lookahead equations live inline in adder32.
- Shared package definitions (existing): add localparam XLEN = 32.
  - Use it for port widths; no new typedefs.
- The fetch instantiation must connect CLK and RST, tie Sub=0 and Cin=0, and may leave the _Q outputs unconnected.

## Test plan
- Increment path: A=0x00000000/0x00000004/0x000003FC, B=4, Sub=0, Cin=0 → OUT=0x4/0x8/0x400; Cout=0, Overflow=0, Zero=0.
- Wrap and flags:
  - 0xFFFFFFFF+1 → OUT=0, Cout=1, Zero=1, Overflow=0.
  - 0x7FFFFFFF+1 → OUT=0x80000000, Overflow=1, Cout=0.
- Subtract:
  - 5−7 → OUT=0xFFFFFFFE, Cout=0.
  - 7−5 → OUT=2, Cout=1.
  - 0x80000000−1 → OUT=0x7FFFFFFF, Overflow=1.
  - A=B=0x12345678 → Zero=1.
- Carry-in: A=0x0000000F, B=0, Cin=1 → OUT=0x10. Same operands with Sub=1 → Cin ignored, OUT=0x0F.
- Registered path and async reset:
  - Apply 3+4 and clock once → OUT_Q=7.
  - Assert RST between edges → OUT_Q and flags 0 immediately; combinational OUT still 7.
  - Release RST, clock → OUT_Q=7.
- Randomized: 10,000 random A, B, Sub, Cin → all outputs match a 33-bit behavioural reference. Include corner values 0, 1, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF.
